sprite_bank_loader: RTL and testbench

Writer side of the sprite pixel store. Accepts a stream of 4-bit palette indices for one 20x20 sprite, writes them into the back bank of a double-buffered pixel RAM, and swaps banks only at a frame boundary so the renderer never shows a half-written sprite. The renderer reads the front bank through a synchronous read port with the same address formula it uses for ROM: `sprite_y*WIDTH + sprite_x`.

---
 rtl/sprite_bank_loader.sv | 119 +++++++++++
 tb/tb_sprite_bank_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_bank_loader.sv
// Writer side of the double-buffered sprite pixel store; swaps banks on frame_start.
// Optional s_last alignment check enabled by SPRITE_LOADER_LAST_CHECK_EN.
module sprite_bank_loader #(
    parameter int WIDTH    = 20,
    parameter int HEIGHT   = 20,
    parameter int PIX_BITS = 4,
    parameter int ADDR_W   = 9
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic                frame_start,
    input  logic                s_valid,
    input  logic [PIX_BITS-1:0] s_data,
    input  logic                s_last,
    output logic                s_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [PIX_BITS-1:0] rd_data,
    output logic                front_bank,
    output logic                swap_done,
    output logic                frame_err
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int MEM_DEPTH = 2 ** (ADDR_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic {
        FILL,
        PENDING
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0]   wr_cnt;
    logic                xfer;
    logic                at_last;
    logic                resync;
    logic                do_swap;
    logic [PIX_BITS-1:0] mem [MEM_DEPTH];

    assign xfer    = s_valid & s_ready;
    assign at_last = (wr_cnt == LAST_ADDR);

`ifdef SPRITE_LOADER_LAST_CHECK_EN
    // Early s_last restarts the sprite so the stream realigns
    assign resync = xfer & s_last & ~at_last;
`else
    assign resync = 1'b0;
`endif

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (xfer && at_last) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_ready = (state_q == FILL);
        do_swap = (state_q == PENDING) && frame_start;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt     <= '0;
            front_bank <= 1'b0;
            swap_done  <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (xfer) begin
                wr_cnt <= (at_last || resync) ? '0 : wr_cnt + ADDR_W'(1);
            end
            front_bank <= front_bank ^ do_swap;
            swap_done  <= do_swap;
            rd_data    <= mem[{front_bank, rd_addr}];
        end
    end

    // Pixel RAM is not reset; back bank is always ~front_bank
    always_ff @(posedge vga_clk) begin
        if (xfer) begin
            mem[{~front_bank, wr_cnt}] <= s_data;
        end
    end

`ifdef SPRITE_LOADER_LAST_CHECK_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else if (xfer && (resync || (at_last && !s_last))) begin
            frame_err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_bank_loader.sv
// Directed self-checking bench for sprite_bank_loader.
// Covers fill/swap control, read sweeps, throttled fill, reset mid-fill, s_last.
module tb_sprite_bank_loader;

    localparam int NPIX = 400;

    logic       vga_clk;
    logic       reset_n;
    logic       frame_start;
    logic       s_valid;
    logic [3:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic [8:0] rd_addr;
    logic [3:0] rd_data;
    logic       front_bank;
    logic       swap_done;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_cnt  = 0;
    bit mdl_ready = 1'b1;
    int data_off = 0;

    typedef struct {
        bit sv;
        bit fs;
        int n;
        bit ready;
        bit front;
        bit swap;
    } vec_t;

    vec_t vecs[8];

    sprite_bank_loader #(
        .WIDTH(20),
        .HEIGHT(20),
        .PIX_BITS(4),
        .ADDR_W(9)
    ) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .front_bank(front_bank),
        .swap_done(swap_done),
        .frame_err(frame_err)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag, input bit r, input bit f,
                              input bit s, input bit e);
        chk({tag, " s_ready"}, int'(s_ready), int'(r));
        chk({tag, " front_bank"}, int'(front_bank), int'(f));
        chk({tag, " swap_done"}, int'(swap_done), int'(s));
        chk({tag, " frame_err"}, int'(frame_err), int'(e));
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // One clock of stream stimulus; the model tracks acceptance for data/s_last
    task automatic cycle(input bit sv, input bit fs);
        s_valid     = sv;
        frame_start = fs;
        s_data      = 4'(mdl_cnt + data_off);
        s_last      = (mdl_cnt == NPIX - 1);
        tick();
        if (mdl_ready && sv) begin
            if (mdl_cnt == NPIX - 1) begin
                mdl_cnt   = 0;
                mdl_ready = 1'b0;
            end else begin
                mdl_cnt++;
            end
        end else if (!mdl_ready && fs) begin
            mdl_ready = 1'b1;
        end
        s_valid     = 1'b0;
        frame_start = 1'b0;
        s_last      = 1'b0;
    endtask

    task automatic sweep(input string tag, input int off);
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = 9'(a);
            cycle(1'b0, 1'b0);
            chk(tag, int'(rd_data), (a + off) & 15);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 200, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1,   1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1,   1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 198, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5,   1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1,   1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1,   1'b1, 1'b1, 1'b0};

        reset_n     = 1'b1;
        frame_start = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        rd_addr     = '0;
        #1 reset_n  = 1'b0;
        tick();
        tick();
        chk_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset rd_data", int'(rd_data), 0);
        reset_n = 1'b1;

        // First load, frame_start mid-fill and on the final transfer, then swap
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                cycle(vecs[v].sv, vecs[v].fs);
            end
            chk_status($sformatf("vec%0d", v), vecs[v].ready,
                       vecs[v].front, vecs[v].swap, 1'b0);
        end

        sweep("sweep1 rd_data", 0);

        // Throttled fill of bank 0 while the renderer reads bank 1
        data_off = 5;
        for (int k = 0; k < 1200; k++) begin
            rd_addr = 9'(k % NPIX);
            cycle(k % 3 == 0, 1'b0);
            chk("throttle old rd_data", int'(rd_data), (k % NPIX) & 15);
        end
        chk_status("throttle pend", 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk_status("throttle swap", 1'b1, 1'b0, 1'b1, 1'b0);
        sweep("sweep2 rd_data", 5);

        data_off = 0;
        for (int i = 0; i < NPIX; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        chk_status("load3 swap", 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset at pixel 150 of a partial load
        for (int i = 0; i < 150; i++) cycle(1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        chk_status("midreset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midreset rd_data", int'(rd_data), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_status("midreset hold", 1'b1, 1'b0, 1'b0, 1'b0);
            chk("midreset hold rd_data", int'(rd_data), 0);
        end
        reset_n   = 1'b1;
        mdl_cnt   = 0;
        mdl_ready = 1'b1;
        data_off  = 9;
        for (int i = 0; i < NPIX - 1; i++) cycle(1'b1, 1'b0);
        chk_status("reload 399", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk_status("reload 400", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk_status("reload swap", 1'b1, 1'b1, 1'b1, 1'b0);
        sweep("sweep3 rd_data", 9);

        // s_last on pixel 10
        for (int i = 0; i < NPIX; i++) begin
            s_valid = 1'b1;
            s_last  = (i == 10);
            s_data  = 4'(i);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
`ifdef SPRITE_LOADER_LAST_CHECK_EN
        chk_status("early last", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            s_valid = 1'b1;
            s_last  = (i == 10);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk_status("early last resync", 1'b0, 1'b1, 1'b0, 1'b1);
`else
        chk_status("early last", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("last swap front_bank", int'(front_bank), 0);
        chk("last swap swap_done", int'(swap_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
